// File: rtl/byte_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : byte_stream_reader
//  Brief    : Latches a byte array and streams a selected, wrapping byte range
//             out one byte per cycle over a valid/ready interface.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_stream_reader #(
    parameter int NBYTES = 32,
    parameter int W      = 8,
    localparam int IW    = $clog2(NBYTES),
    localparam int RW    = IW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NBYTES*W-1:0] in_data,
    input  logic [31:0]         in_start,
    input  logic [31:0]         in_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic [IW-1:0]       out_idx,
    output logic                out_last,
    output logic                trunc,
    output logic                busy
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [NBYTES-1:0][W-1:0] mem_q, mem_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [RW-1:0]            rem_q, rem_d;
    logic                     trunc_q, trunc_d;

    logic w_stream;
    logic w_load;
    logic w_xfer;
    logic w_clip;
    logic w_unused_start_hi;

    assign w_stream          = (state_q == STREAM);
    assign w_load            = in_valid && in_ready;
    assign w_xfer            = out_valid && out_ready;
    assign w_clip            = (in_len > 32'(NBYTES));
    assign w_unused_start_hi = ^in_start[31:IW];

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        trunc_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    mem_d   = in_data;
                    idx_d   = in_start[IW-1:0];
                    rem_d   = w_clip ? RW'(NBYTES) : in_len[RW-1:0];
                    trunc_d = w_clip;
                    // A zero-length load is accepted but produces no stream.
                    if (in_len != 32'd0) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (w_xfer) begin
                    idx_d = idx_q + IW'(1);
                    rem_d = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            trunc_q <= trunc_d;
        end
    end

    // Buffer contents are irrelevant after reset; loads are blocked while rst is high.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready  = !w_stream && !rst;
    assign out_valid = w_stream;
    assign out_data  = w_stream ? mem_q[idx_q] : '0;
    assign out_idx   = w_stream ? idx_q : '0;
    assign out_last  = w_stream && (rem_q == RW'(1));
    assign trunc     = trunc_q;
    assign busy      = w_stream;

endmodule
`default_nettype wire

// File: tb/tb_byte_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_stream_reader
//  Brief    : Scoreboard bench: loads push expected bytes, a monitor pops and
//             compares on every output transfer and checks stall stability.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_stream_reader;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB*8-1:0] in_data = '0;
    logic [31:0]   in_start = '0;
    logic [31:0]   in_len = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;
    logic [4:0]    out_idx;
    logic          out_last;
    logic          trunc;
    logic          busy;

    byte_stream_reader #(.NBYTES(NB), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_start  (in_start),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .trunc     (trunc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [4:0] i;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_xfer = 0;
    int   trunc_cnt = 0;
    bit   pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: stall stability and scoreboard compare on each transfer
    logic       stall_prev = 1'b0;
    logic [7:0] prev_d;
    logic [4:0] prev_i;
    logic       prev_l;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_stable", {out_valid, out_last, out_idx, out_data},
                    {1'b1, prev_l, prev_i, prev_d});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {out_idx, out_data}, 32'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("byte", {out_last, out_idx, out_data}, {e.l, e.i, e.d});
                end
                n_xfer++;
            end
            if (trunc) trunc_cnt++;
            stall_prev = out_valid && !out_ready;
            prev_d = out_data;
            prev_i = out_idx;
            prev_l = out_last;
        end
    end

    task automatic fill(input int base);
        for (int i = 0; i < NB; i++) in_data[i*8 +: 8] = 8'(base + i);
    endtask

    // Entered and left at posedge+1
    task automatic load(input int start, input int len, input int base);
        int n;
        fill(base);
        in_start = 32'(start);
        in_len   = 32'(len);
        in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_at_load", {31'd0, in_ready}, 32'd1);
        n = (len > NB) ? NB : len;
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.i = 5'((start + k) % NB);
            e.d = 8'(base + (start + k) % NB);
            e.l = (k == n - 1);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit bp);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (bp) out_ready = pat[i % 6];
            @(negedge clk); #1;
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("drain_timeout", {31'd0, done}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        // Reset
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {out_valid, out_last, trunc, busy, in_ready, out_idx, out_data},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'd0});
        @(posedge clk); #1;

        // Basic: last-byte handshake and one-cycle bubble
        load(0, 4, 16);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (out_valid && out_last) seen = 1'b1;
        end
        chk("basic_last_seen", {31'd0, seen}, 32'd1);
        chk("in_ready_last_cycle", {31'd0, in_ready}, 32'd0);
        @(negedge clk); #1;
        chk("after_last", {29'd0, in_ready, out_valid, busy}, {29'd0, 3'b100});
        chk("basic_queue_empty", exp_q.size(), 32'd0);
        chk("basic_no_trunc", trunc_cnt, 32'd0);
        @(posedge clk); #1;

        // Wrap around the end of the array
        load(30, 5, 16);
        drain(1'b0);

        // Clipped length
        trunc_cnt = 0;
        load(5, 40, 8'hA0);
        drain(1'b0);
        chk("clip_trunc_once", trunc_cnt, 32'd1);

        // Zero length
        n_xfer = 0;
        load(7, 0, 0);
        @(negedge clk); #1;
        chk("zero_len_idle", {29'd0, out_valid, in_ready, trunc}, {29'd0, 3'b010});
        @(posedge clk); #1;
        chk("zero_len_no_xfer", n_xfer, 32'd0);

        // Backpressure
        load(12, 6, 8'h50);
        drain(1'b1);

        // Reset mid-stream
        n_xfer = 0;
        load(10, 8, 8'h40);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk); #1;
                if (n_xfer >= 2) ok = 1'b1;
            end
            chk("two_bytes_before_rst", {31'd0, ok}, 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("midstream_reset", {out_valid, out_last, trunc, busy, in_ready, out_idx, out_data},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'd0});
        @(posedge clk); #1;
        load(20, 3, 8'h01);
        drain(1'b0);

        // Input isolation during a stream
        load(3, 6, 8'h80);
        for (int i = 0; i < 3; i++) begin
            fill(8'hC0 + i * 7);
            in_start = 32'd0;
            in_len   = 32'd2;
            in_valid = 1'b1;
            @(negedge clk); #1;
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("final_idle", {30'd0, out_valid, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
